// File: rtl/pipe_ctrl_pkg.sv
// Purpose: shared types and encodings for the pipelined control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: ctrl_t control word, CTRL_W/CTRL_NOP, instruction types, alu_op and func codes.
package pipe_ctrl_pkg;

    typedef struct packed {
        logic       branch_b;
        logic       branch_i;
        logic       branch_leq;
        logic       branch_geq;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] imm_src;
        logic       reg_src2;
        logic       reg_src1;
    } ctrl_t;

    localparam int    CTRL_W   = $bits(ctrl_t);
    localparam ctrl_t CTRL_NOP = '0;

    // Instruction types
    localparam logic [1:0] TYPE_MEM  = 2'b00;
    localparam logic [1:0] TYPE_DATA = 2'b01;
    localparam logic [1:0] TYPE_CTRL = 2'b10;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_DIV = 3'b011;
    localparam logic [2:0] ALU_OP4 = 3'b100;
    localparam logic [2:0] ALU_OP5 = 3'b101;
    localparam logic [2:0] ALU_OP6 = 3'b110;

    // DATA-type function codes: func[4]=0 register form, func[4]=1 immediate form
    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_SUB  = 5'b00001;
    localparam logic [4:0] F_MUL  = 5'b00010;
    localparam logic [4:0] F_DIV  = 5'b00011;
    localparam logic [4:0] F_R6   = 5'b01011;
    localparam logic [4:0] F_ADDI = 5'b10100;
    localparam logic [4:0] F_SUBI = 5'b10101;
    localparam logic [4:0] F_MULI = 5'b10110;
    localparam logic [4:0] F_DIVI = 5'b10111;
    localparam logic [4:0] F_I4   = 5'b11000;
    localparam logic [4:0] F_I5   = 5'b11001;
    localparam logic [4:0] F_I6A  = 5'b11010;
    localparam logic [4:0] F_I6B  = 5'b11100;

    // MEM-type and CTRL-type sub-selects on func[4:3]
    localparam logic [1:0] M_LOAD  = 2'b00;
    localparam logic [1:0] M_STORE = 2'b01;
    localparam logic [1:0] B_B     = 2'b00;
    localparam logic [1:0] B_LEQ   = 2'b01;
    localparam logic [1:0] B_I     = 2'b10;
    localparam logic [1:0] B_GEQ   = 2'b11;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Purpose: decode-side bus between the front end and pipe_ctrl_unit.
// Latency: n/a (wires only).
// Backpressure: stall_o holds PC and IF/ID, flush_o clears IF/ID.
// Ports: ID inputs (id_valid_i, instr_type_i, func_i, rs1_i, rs2_i, rd_i, branch_taken_i);
//        outputs (ex/mem/wb_ctrl_o, stall_o, flush_o, illegal_o). slave = control unit side.
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 4
) ();

    logic             id_valid_i;
    logic [1:0]       instr_type_i;
    logic [4:0]       func_i;
    logic [REG_W-1:0] rs1_i;
    logic [REG_W-1:0] rs2_i;
    logic [REG_W-1:0] rd_i;
    logic             branch_taken_i;
    ctrl_t            ex_ctrl_o;
    ctrl_t            mem_ctrl_o;
    ctrl_t            wb_ctrl_o;
    logic             stall_o;
    logic             flush_o;
    logic             illegal_o;

    modport slave (
        input  id_valid_i, instr_type_i, func_i, rs1_i, rs2_i, rd_i, branch_taken_i,
        output ex_ctrl_o, mem_ctrl_o, wb_ctrl_o, stall_o, flush_o, illegal_o
    );

    modport master (
        output id_valid_i, instr_type_i, func_i, rs1_i, rs2_i, rd_i, branch_taken_i,
        input  ex_ctrl_o, mem_ctrl_o, wb_ctrl_o, stall_o, flush_o, illegal_o
    );

endinterface

// File: rtl/pipe_ctrl_decode.sv
// Purpose: combinational ID decode of instr_type/func into a ctrl_t plus hazard side-info.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; re-evaluated every cycle while the instruction sits stalled in ID.
// Ports: id_valid_i, instr_type_i, func_i in; ctrl_o, rs1/rs2_used_o, is_mul/div_o, illegal_o out.
// PIPE_CTRL_ILLEGAL_TRAP_EN enables illegal_o; otherwise it is tied 0.
module pipe_ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic       id_valid_i,
    input  logic [1:0] instr_type_i,
    input  logic [4:0] func_i,
    output ctrl_t      ctrl_o,
    output logic       rs1_used_o,
    output logic       rs2_used_o,
    output logic       is_mul_o,
    output logic       is_div_o,
    output logic       illegal_o
);

    ctrl_t      ctrl;
    logic       legal;
    logic       rs2;
    logic       mul;
    logic       div;
    logic [2:0] alu;

    always_comb begin
        ctrl  = CTRL_NOP;
        legal = 1'b0;
        rs2   = 1'b0;
        mul   = 1'b0;
        div   = 1'b0;
        alu   = ALU_ADD;

        case (instr_type_i)
            TYPE_DATA: begin
                legal = 1'b1;
                case (func_i)
                    F_ADD, F_ADDI: alu = ALU_ADD;
                    F_SUB, F_SUBI: alu = ALU_SUB;
                    F_MUL, F_MULI: begin alu = ALU_MUL; mul = 1'b1; end
                    F_DIV, F_DIVI: begin alu = ALU_DIV; div = 1'b1; end
                    F_I4:          alu = ALU_OP4;
                    F_I5:          alu = ALU_OP5;
                    F_R6, F_I6A, F_I6B: alu = ALU_OP6;
                    default:       legal = 1'b0;
                endcase
                if (legal) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = alu;
                    if (func_i[4]) begin
                        ctrl.alu_src = 1'b1;
                        ctrl.imm_src = 2'b10;
                    end else begin
                        rs2 = 1'b1;
                    end
                end
            end
            TYPE_CTRL: begin
                legal         = 1'b1;
                rs2           = 1'b1;
                ctrl.alu_op   = ALU_SUB;
                ctrl.reg_src1 = 1'b1;
                ctrl.reg_src2 = 1'b1;
                case (func_i[4:3])
                    B_B:     ctrl.branch_b   = 1'b1;
                    B_LEQ:   ctrl.branch_leq = 1'b1;
                    B_I:     ctrl.branch_i   = 1'b1;
                    default: ctrl.branch_geq = 1'b1;
                endcase
            end
            TYPE_MEM: begin
                case (func_i[4:3])
                    M_LOAD: begin
                        legal           = 1'b1;
                        ctrl.mem_read   = 1'b1;
                        ctrl.mem_to_reg = 1'b1;
                        ctrl.reg_write  = 1'b1;
                    end
                    M_STORE: begin
                        legal          = 1'b1;
                        rs2            = 1'b1;
                        ctrl.mem_write = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
                if (legal) begin
                    ctrl.alu_src = 1'b1;
                    ctrl.alu_op  = ALU_ADD;
                    ctrl.imm_src = 2'b10;
                end
            end
            default: legal = 1'b0;
        endcase
    end

    // An empty ID slot decodes as NOP and claims no sources.
    assign ctrl_o     = id_valid_i ? ctrl : CTRL_NOP;
    assign rs1_used_o = id_valid_i && legal;
    assign rs2_used_o = id_valid_i && legal && rs2;
    assign is_mul_o   = id_valid_i && mul;
    assign is_div_o   = id_valid_i && div;

`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
    assign illegal_o = id_valid_i && !legal;
`else
    assign illegal_o = 1'b0;
`endif

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Purpose: ID decode, ID/EX -> EX/MEM -> MEM/WB control pipeline and hazard control.
// Latency: ctrl reaches EX 1 edge after decode, MEM after 2, WB after 3.
// Backpressure: stall_o on load-use or mul/div hold, flush_o on a taken branch; rst > hold > flush > load-use.
// Ports: clk, rst (sync, active-high); bus (pipe_ctrl_if.slave) carries ID inputs and stage outputs.
// PIPE_CTRL_ILLEGAL_TRAP_EN (in pipe_ctrl_decode) enables illegal_o.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W   = 4,
    parameter int MUL_LAT = 1,
    parameter int DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    ctrl_t            dec_ctrl;
    logic             rs1_used, rs2_used, is_mul, is_div, dec_illegal;

    ctrl_t            ex_ctrl_q,  ex_ctrl_d;
    ctrl_t            mem_ctrl_q, mem_ctrl_d;
    ctrl_t            wb_ctrl_q,  wb_ctrl_d;
    logic [REG_W-1:0] ex_rd_q,    ex_rd_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic             hold, load_use;

    pipe_ctrl_decode u_decode (
        .id_valid_i   (bus.id_valid_i),
        .instr_type_i (bus.instr_type_i),
        .func_i       (bus.func_i),
        .ctrl_o       (dec_ctrl),
        .rs1_used_o   (rs1_used),
        .rs2_used_o   (rs2_used),
        .is_mul_o     (is_mul),
        .is_div_o     (is_div),
        .illegal_o    (dec_illegal)
    );

    always_comb begin
        // The counter is only ever non-zero while a mul/div occupies EX.
        hold     = (hold_cnt_q != '0);
        load_use = ex_ctrl_q.mem_read &&
                   ((rs1_used && (ex_rd_q == bus.rs1_i)) ||
                    (rs2_used && (ex_rd_q == bus.rs2_i)));

        ex_ctrl_d  = ex_ctrl_q;
        ex_rd_d    = ex_rd_q;
        mem_ctrl_d = ex_ctrl_q;
        wb_ctrl_d  = mem_ctrl_q;
        hold_cnt_d = '0;

        if (hold) begin
            // mul/div stays in EX; bubbles flow downstream; branch resolution is ignored.
            mem_ctrl_d = CTRL_NOP;
            hold_cnt_d = hold_cnt_q - CNT_W'(1);
        end else if (bus.branch_taken_i) begin
            ex_ctrl_d = CTRL_NOP;
            ex_rd_d   = '0;
        end else if (load_use) begin
            ex_ctrl_d = CTRL_NOP;
            ex_rd_d   = '0;
        end else begin
            ex_ctrl_d = dec_ctrl;
            ex_rd_d   = bus.rd_i;
            // Loading LAT-1 here lets a back-to-back mul/div reload on the hand-off edge.
            if (is_mul)
                hold_cnt_d = CNT_W'(MUL_LAT - 1);
            else if (is_div)
                hold_cnt_d = CNT_W'(DIV_LAT - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctrl_q  <= CTRL_NOP;
            mem_ctrl_q <= CTRL_NOP;
            wb_ctrl_q  <= CTRL_NOP;
            ex_rd_q    <= '0;
            hold_cnt_q <= '0;
        end else begin
            ex_ctrl_q  <= ex_ctrl_d;
            mem_ctrl_q <= mem_ctrl_d;
            wb_ctrl_q  <= wb_ctrl_d;
            ex_rd_q    <= ex_rd_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign bus.ex_ctrl_o  = ex_ctrl_q;
    assign bus.mem_ctrl_o = mem_ctrl_q;
    assign bus.wb_ctrl_o  = wb_ctrl_q;
    // Reset outranks every hazard, so the strobes read 0 while rst is high.
    assign bus.stall_o    = !rst && (hold || (load_use && !bus.branch_taken_i));
    assign bus.flush_o    = !rst && !hold && bus.branch_taken_i;
    assign bus.illegal_o  = !rst && dec_illegal;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Purpose: directed scoreboard bench for pipe_ctrl_unit (REG_W=4, MUL_LAT=1, DIV_LAT=8).
// Latency: one expected-output entry per clock cycle, checked on the falling edge.
// Backpressure: stall/flush cases are driven explicitly by re-presenting the ID instruction.
module tb_pipe_ctrl_unit;
    import pipe_ctrl_pkg::*;

    // Expected control words, bit order as ctrl_t (branch_b at bit 15 ... reg_src1 at bit 0)
    localparam logic [15:0] N     = 16'h0000;
    localparam logic [15:0] ADD   = 16'h0010; // reg_write
    localparam logic [15:0] LOAD  = 16'h0C38; // mem_to_reg mem_read alu_src reg_write imm=10
    localparam logic [15:0] STORE = 16'h0228; // mem_write alu_src imm=10
    localparam logic [15:0] DIVI  = 16'h00F8; // alu_op=011 alu_src reg_write imm=10
    localparam logic [15:0] MUL   = 16'h0090; // alu_op=010 reg_write
    localparam logic [15:0] BLEQ  = 16'h2043; // branch_leq alu_op=001 reg_src2 reg_src1

    // {instr_type, func}
    localparam logic [6:0] OP_ADD   = 7'b01_00000;
    localparam logic [6:0] OP_LOAD  = 7'b00_00000;
    localparam logic [6:0] OP_STORE = 7'b00_01000;
    localparam logic [6:0] OP_DIVI  = 7'b01_10111;
    localparam logic [6:0] OP_MUL   = 7'b01_00010;
    localparam logic [6:0] OP_BLEQ  = 7'b10_01000;
    localparam logic [6:0] OP_T11   = 7'b11_00000;
    localparam logic [6:0] OP_BAD   = 7'b01_01111;

`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
    localparam bit ILL = 1'b1;
`else
    localparam bit ILL = 1'b0;
`endif

    typedef struct {
        logic [15:0] ex;
        logic [15:0] mem;
        logic [15:0] wb;
        logic        st;
        logic        fl;
        logic        il;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_no   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_no <= cyc_no + 1;

    pipe_ctrl_if #(.REG_W(4)) bus ();

    pipe_ctrl_unit #(
        .REG_W   (4),
        .MUL_LAT (1),
        .DIV_LAT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc_no, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle, so each falling edge consumes one entry.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            logic [15:0] a_ex, a_mem, a_wb;
            e     = sb_q.pop_front();
            a_ex  = bus.ex_ctrl_o;
            a_mem = bus.mem_ctrl_o;
            a_wb  = bus.wb_ctrl_o;
            chk("ex_ctrl",  a_ex,  e.ex);
            chk("mem_ctrl", a_mem, e.mem);
            chk("wb_ctrl",  a_wb,  e.wb);
            chk("stall",    {15'd0, bus.stall_o},   {15'd0, e.st});
            chk("flush",    {15'd0, bus.flush_o},   {15'd0, e.fl});
            chk("illegal",  {15'd0, bus.illegal_o}, {15'd0, e.il});
        end
    end

    task automatic cyc(input bit r, input bit v, input logic [6:0] op,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] d, input bit bt,
                       input logic [15:0] e_ex, input logic [15:0] e_mem, input logic [15:0] e_wb,
                       input bit e_st, input bit e_fl, input bit e_il);
        exp_t e;
        rst                = r;
        bus.id_valid_i     = v;
        bus.instr_type_i   = op[6:5];
        bus.func_i         = op[4:0];
        bus.rs1_i          = a;
        bus.rs2_i          = b;
        bus.rd_i           = d;
        bus.branch_taken_i = bt;
        e.ex  = e_ex;
        e.mem = e_mem;
        e.wb  = e_wb;
        e.st  = e_st;
        e.fl  = e_fl;
        e.il  = e_il;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [15:0] e_ex, input logic [15:0] e_mem, input logic [15:0] e_wb);
        cyc(0, 0, OP_LOAD, 4'd0, 4'd0, 4'd0, 0, e_ex, e_mem, e_wb, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc_no);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.id_valid_i     = 1'b0;
        bus.instr_type_i   = 2'b00;
        bus.func_i         = 5'd0;
        bus.rs1_i          = 4'd0;
        bus.rs2_i          = 4'd0;
        bus.rd_i           = 4'd0;
        bus.branch_taken_i = 1'b0;
        @(posedge clk);
        #1;

        // Reset held two cycles with random ID inputs
        for (int i = 0; i < 2; i++)
            cyc(1, 1'($urandom), 7'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                1'($urandom), N, N, N, 0, 0, 0);

        // Plain add walks EX, MEM, WB
        cyc(0, 1, OP_ADD, 4'd1, 4'd2, 4'd5, 0, N, N, N, 0, 0, 0);
        idle(ADD, N, N);
        idle(N, ADD, N);
        idle(N, N, ADD);

        // Load to r3 then add using r3: one stall, bubble into EX
        cyc(0, 1, OP_LOAD, 4'd2, 4'd0, 4'd3, 0, N,    N,    N, 0, 0, 0);
        cyc(0, 1, OP_ADD,  4'd3, 4'd4, 4'd6, 0, LOAD, N,    N, 1, 0, 0);
        cyc(0, 1, OP_ADD,  4'd3, 4'd4, 4'd6, 0, N,    LOAD, N, 0, 0, 0);
        idle(ADD, N, LOAD);
        idle(N, ADD, N);
        idle(N, N, ADD);

        // Load rs2 is unused (no stall); store rs2 is used (stall)
        cyc(0, 1, OP_LOAD,  4'd0, 4'd0, 4'd7, 0, N,    N,    N,    0, 0, 0);
        cyc(0, 1, OP_LOAD,  4'd1, 4'd7, 4'd8, 0, LOAD, N,    N,    0, 0, 0);
        cyc(0, 1, OP_STORE, 4'd0, 4'd8, 4'd0, 0, LOAD, LOAD, N,    1, 0, 0);
        cyc(0, 1, OP_STORE, 4'd0, 4'd8, 4'd0, 0, N,    LOAD, LOAD, 0, 0, 0);
        idle(STORE, N, LOAD);
        idle(N, STORE, N);
        idle(N, N, STORE);

        // divi (8 EX cycles, 7 stalls); a taken branch during the hold is ignored
        cyc(0, 1, OP_DIVI, 4'd1, 4'd0, 4'd9, 0, N, N, N, 0, 0, 0);
        for (int i = 0; i < 7; i++)
            cyc(0, 1, OP_ADD, 4'd2, 4'd3, 4'd4, (i == 2), DIVI, N, N, 1, 0, 0);
        cyc(0, 1, OP_ADD, 4'd2, 4'd3, 4'd4, 0, DIVI, N, N, 0, 0, 0);
        idle(ADD, DIVI, N);
        idle(N, ADD, DIVI);
        idle(N, N, ADD);

        // mul with MUL_LAT=1: no stall
        cyc(0, 1, OP_MUL, 4'd1, 4'd0, 4'd2, 0, N,   N, N, 0, 0, 0);
        cyc(0, 1, OP_ADD, 4'd2, 4'd3, 4'd4, 0, MUL, N, N, 0, 0, 0);
        idle(ADD, MUL, N);
        idle(N, ADD, MUL);
        idle(N, N, ADD);

        // Taken branch flushes the instruction behind it
        cyc(0, 1, OP_BLEQ, 4'd1, 4'd2, 4'd0, 0, N,    N, N, 0, 0, 0);
        cyc(0, 1, OP_ADD,  4'd1, 4'd2, 4'd3, 1, BLEQ, N, N, 0, 1, 0);
        idle(N, BLEQ, N);
        idle(N, N, BLEQ);

        // Flush outranks a simultaneous load-use
        cyc(0, 1, OP_LOAD, 4'd0, 4'd0, 4'd5, 0, N,    N, N, 0, 0, 0);
        cyc(0, 1, OP_ADD,  4'd5, 4'd0, 4'd6, 1, LOAD, N, N, 0, 1, 0);
        idle(N, LOAD, N);
        idle(N, N, LOAD);

        // Undefined encodings decode as NOP; illegal only when valid
        cyc(0, 1, OP_T11, 4'd1, 4'd2, 4'd3, 0, N, N, N, 0, 0, ILL);
        cyc(0, 1, OP_BAD, 4'd1, 4'd2, 4'd3, 0, N, N, N, 0, 0, ILL);
        cyc(0, 0, OP_T11, 4'd1, 4'd2, 4'd3, 0, N, N, N, 0, 0, 0);
        idle(N, N, N);

        // Reset during the 4th hold cycle clears everything, no residual stall
        cyc(0, 1, OP_DIVI, 4'd1, 4'd0, 4'd9, 0, N, N, N, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc(0, 0, OP_LOAD, 4'd0, 4'd0, 4'd0, 0, DIVI, N, N, 1, 0, 0);
        cyc(1, 0, OP_LOAD, 4'd0, 4'd0, 4'd0, 0, DIVI, N, N, 0, 0, 0);
        cyc(0, 1, OP_ADD,  4'd1, 4'd2, 4'd3, 0, N,    N, N, 0, 0, 0);
        idle(ADD, N, N);
        idle(N, ADD, N);
        idle(N, N, ADD);

        for (int i = 0; i < 4 && sb_q.size() != 0; i++)
            @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain actual=%0d expected=0 entries left", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined successor to the single-stage decoder: decodes the 2-bit instruction type and 5-bit function field in ID into a control word. It carries that word through ID/EX, EX/MEM and MEM/WB registers. It also owns hazard control: load-use stall, taken-branch flush, and a parametrised multi-cycle hold for mul/div in EX. It sits between the fetch/decode front end and the datapath stage registers.

## Interface
- REG_W, 4, register-address width
- MUL_LAT, 1, EX cycles occupied by mul/multi (≥1)
- DIV_LAT, 8, EX cycles occupied by div/divi (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- id_valid_i  in  1  ID holds a real instruction; 0 means decode as NOP
- instr_type_i  in  2  instruction type
- func_i  in  5  function field
- rs1_i, rs2_i, rd_i  in  REG_W  ID register addresses
- branch_taken_i  in  1  branch in EX resolved taken
- ex_ctrl_o, mem_ctrl_o, wb_ctrl_o  out  CTRL_W  registered ctrl_t for each stage
- stall_o  out  1  hold PC and IF/ID
- flush_o  out  1  clear IF/ID
- illegal_o  out  1  undefined encoding in ID (macro only, else tied 0)

## Operation
- ctrl_t fields: branch_b, branch_i, branch_leq, branch_geq, mem_to_reg, mem_read, mem_write, alu_op[2:0], alu_src, reg_write, imm_src[1:0], reg_src2, reg_src1. NOP = all zero. Don't-care fields drive 0.
- Type 01, func[4]=0: reg_write=1, alu_src=0. alu_op: 00000→000, 00001→001, 00010→010 (mul), 00011→011 (div), 01011→110.
- Type 01, func[4]=1: reg_write=1, alu_src=1, imm_src=10. alu_op: 10100→000, 10101→001, 10110→010 (mul), 10111→011 (div), 11000→100, 11001→101, 11010→110, 11100→110.
- Type 10: alu_op=001, reg_src1=reg_src2=1, imm_src=00. func[4:3] selects the branch flag: 00 b, 01 leq, 10 i, 11 geq.
- Type 00: alu_src=1, alu_op=000, imm_src=10.
  - func[4:3]=00 load: mem_read, mem_to_reg, reg_write.
  - 01: store, mem_write.
- Type 11 and any other unlisted func: NOP.
- rs1 is used by every non-NOP instruction. rs2 is used by type 01 func[4]=0, by type 10, and by store.
- Load-use: ex_ctrl_o.mem_read=1 and ex_rd equals a used ID source → stall_o=1, ID/EX loads NOP.
- Taken branch: flush_o=1, ID/EX loads NOP, the branch advances to MEM normally.
- Multi-cycle hold: a mul/div in EX with hold counter ≠0 → stall_o=1, ID/EX held, EX/MEM loads NOP, counter decrements.
- Priority: rst > hold > flush > load-use. branch_taken_i is ignored while the counter ≠0.

## Timing
- Reset values: all ctrl outputs NOP, ex_rd=0, counter=0, stall_o=0, flush_o=0, illegal_o=0.
- Decode is combinational in ID. Latency: 1 edge to EX, 2 to MEM, 3 to WB.
- stall_o, flush_o and illegal_o are combinational from the current inputs and registered state, in the same cycle.
- Counter loads LAT-1 on the edge that moves a mul/div into ID/EX, otherwise 0. An op with LAT=N therefore spends exactly N cycles in EX with N-1 stall cycles. LAT=1 gives no stall.
- A stalled ID instruction is re-decoded every cycle. It enters EX on the first non-stall edge.
- Back-to-back div ops: the counter reloads on the hand-off edge, with no gap cycle.
- rst mid-hold clears the counter and all stage registers at that edge.

## Configuration
- PIPE_CTRL_ILLEGAL_TRAP_EN defined: an undefined encoding with id_valid_i=1 drives illegal_o=1 for that cycle. The instruction still enters as NOP.
- Undefined: illegal_o is tied 0 and decode is otherwise identical.

## Structure
- Package pipe_ctrl_pkg holds:
  - the ctrl_t packed struct, CTRL_W and CTRL_NOP;
  - instruction-type localparams (MEM=00, DATA=01, CTRL=10);
  - alu_op and func-code constants.
- Sub-module pipe_ctrl_decode: purely combinational instr_type/func→ctrl_t plus the illegal flag and rs-used flags.
- The top module holds the stage registers, hazard logic and hold counter.

## Test plan
- rst held 2 cycles, random inputs → all outputs NOP/0. Release, then type 01 func 00000 → ex_ctrl_o alu_op=000, reg_write=1 next cycle; wb_ctrl_o reg_write=1 three cycles after decode.
- Load to rd=3, then add with rs1=3 → stall_o=1 for exactly one cycle and a NOP in EX. The add reaches EX one cycle late.
- DIV_LAT=8, divi followed by add → stall_o high 7 cycles, 7 NOPs into MEM. The add enters EX on cycle 9.
- Type 10 func 01000 in EX with branch_taken_i=1 → flush_o=1 and ID/EX=NOP. mem_ctrl_o.branch_leq=1 next cycle.
- Macro defined, type 11 valid → illegal_o=1 and NOP flows. Macro undefined → illegal_o=0.
- rst asserted during the 4th div hold cycle → the counter and all ctrl outputs are NOP/0 after that edge, with no residual stall.
